// File: rtl/event_queue_arbiter_if.sv
// rtl/event_queue_arbiter_if.sv - write-event / read-request bundle for event_queue_arbiter
interface event_queue_arbiter_if #(
  parameter int NCH   = 4,
  parameter int DEPTH = 32
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                live_rising;
  logic [NCH-1:0]      w_complete;
  logic                r_submit;
  logic                r_request;
  logic [CHW-1:0]      r_ch;
  logic [NCH*CW-1:0]   nqueue;
  logic [NCH-1:0]      full;
  logic [NCH-1:0]      overflow;
  logic                proto_err;

  modport master (
    output live_rising, w_complete, r_submit,
    input  r_request, r_ch, nqueue, full, overflow, proto_err
  );

  modport slave (
    input  live_rising, w_complete, r_submit,
    output r_request, r_ch, nqueue, full, overflow, proto_err
  );
endinterface

// File: rtl/event_queue_arbiter.sv
// rtl/event_queue_arbiter.sv - per-channel event occupancy counters with round-robin read request
module event_queue_arbiter #(
  parameter int NCH   = 4,
  parameter int DEPTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  event_queue_arbiter_if.slave eq
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, REQ, ARB} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt [NCH];
  logic [CHW-1:0]  r_ptr, w_ptr_nxt;
  logic [CHW-1:0]  r_chq, w_ch_nxt, w_win;
  logic            r_req, w_req_nxt, w_any;
  logic [NCH-1:0]  r_ovf, w_full, w_dec;
  logic            r_perr, w_valid;
  logic [NCH*CW-1:0] w_nq;

  assign w_valid = eq.r_submit & r_req;

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      assign w_full[g]            = (r_cnt[g] == CW'(DEPTH));
      assign w_dec[g]             = w_valid & (r_chq == CHW'(g));
      assign w_nq[g*CW +: CW]     = r_cnt[g];
    end
  endgenerate

  // First non-empty channel at or after the pointer, wrapping.
  always_comb begin
    logic [CHW-1:0] idx;
    w_win = '0;
    w_any = 1'b0;
    idx   = '0;
    for (int off = 0; off < NCH; off++) begin
      idx = ((int'(r_ptr) + off) >= NCH) ? CHW'(int'(r_ptr) + off - NCH)
                                         : CHW'(int'(r_ptr) + off);
      if (!w_any && (r_cnt[idx] != '0)) begin
        w_any = 1'b1;
        w_win = idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_ch_nxt    = r_chq;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE, ARB: begin
        w_req_nxt = 1'b0;
        if (w_any) begin
          w_state_nxt = REQ;
          w_req_nxt   = 1'b1;
          w_ch_nxt    = w_win;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        if (eq.r_submit) begin
          w_state_nxt = ARB;
          w_req_nxt   = 1'b0;
          w_ptr_nxt   = (r_chq == CHW'(NCH - 1)) ? '0 : r_chq + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_chq   <= '0;
      r_ptr   <= '0;
      r_ovf   <= '0;
      r_perr  <= 1'b0;
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else if (eq.live_rising) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_chq   <= '0;
      r_ptr   <= '0;
      r_ovf   <= '0;
      r_perr  <= 1'b0;
      for (int i = 0; i < NCH; i++) r_cnt[i] <= {{(CW-1){1'b0}}, eq.w_complete[i]};
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_chq   <= w_ch_nxt;
      r_ptr   <= w_ptr_nxt;
      r_perr  <= r_perr | (eq.r_submit & ~r_req);
      // A write and a granted read on the same channel cancel, even when full.
      for (int i = 0; i < NCH; i++) begin
        if (eq.w_complete[i] && !w_dec[i]) begin
          if (w_full[i]) r_ovf[i] <= 1'b1;
          else           r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (!eq.w_complete[i] && w_dec[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  assign eq.r_request = r_req;
  assign eq.r_ch      = r_chq;
  assign eq.nqueue    = w_nq;
  assign eq.full      = w_full;
  assign eq.overflow  = r_ovf;
  assign eq.proto_err = r_perr;
endmodule

// File: tb/tb_event_queue_arbiter.sv
// tb/tb_event_queue_arbiter.sv - directed and randomized bench for event_queue_arbiter
module tb_event_queue_arbiter;
  localparam int NCH   = 4;
  localparam int DEPTH = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  event_queue_arbiter_if #(.NCH(NCH), .DEPTH(DEPTH)) eq ();
  event_queue_arbiter #(.NCH(NCH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .eq(eq));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int dcnt(input int ch);
    return int'(eq.nqueue[ch*CW +: CW]);
  endfunction

  // Reference: a request is either outstanding or not; when none is, grant
  // the next pending channel from the pointer using the pre-edge counts.
  int m_cnt [NCH];
  int nc    [NCH];
  bit m_ovf [NCH];
  bit m_perr, m_req, m_valid, m_found;
  int m_ch, m_ptr, m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin m_cnt[i] = 0; m_ovf[i] = 0; end
      m_perr = 0; m_req = 0; m_ch = 0; m_ptr = 0;
    end else if (eq.live_rising) begin
      for (int i = 0; i < NCH; i++) begin m_cnt[i] = eq.w_complete[i] ? 1 : 0; m_ovf[i] = 0; end
      m_perr = 0; m_req = 0; m_ch = 0; m_ptr = 0;
    end else begin
      m_valid = eq.r_submit && m_req;
      for (int i = 0; i < NCH; i++) begin
        nc[i] = m_cnt[i];
        if (eq.w_complete[i] && !(m_valid && m_ch == i)) begin
          if (m_cnt[i] == DEPTH) m_ovf[i] = 1;
          else nc[i] = m_cnt[i] + 1;
        end else if (!eq.w_complete[i] && m_valid && m_ch == i && m_cnt[i] > 0) begin
          nc[i] = m_cnt[i] - 1;
        end
      end
      if (eq.r_submit && !m_req) m_perr = 1;
      if (m_req) begin
        if (eq.r_submit) begin m_req = 0; m_ptr = (m_ch + 1) % NCH; end
      end else begin
        m_found = 0;
        for (int off = 0; off < NCH; off++) begin
          m_idx = (m_ptr + off) % NCH;
          if (!m_found && m_cnt[m_idx] > 0) begin m_found = 1; m_ch = m_idx; end
        end
        m_req = m_found;
      end
      for (int i = 0; i < NCH; i++) m_cnt[i] = nc[i];
    end
  end

  always @(negedge clk) begin
    chk("r_request", int'(eq.r_request), int'(m_req));
    if (m_req) chk("r_ch", int'(eq.r_ch), m_ch);
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("nqueue[%0d]", i), dcnt(i), m_cnt[i]);
      chk($sformatf("full[%0d]", i), int'(eq.full[i]), (m_cnt[i] == DEPTH) ? 1 : 0);
      chk($sformatf("overflow[%0d]", i), int'(eq.overflow[i]), int'(m_ovf[i]));
    end
    chk("proto_err", int'(eq.proto_err), int'(m_perr));
  end

  task automatic cyc(input logic [NCH-1:0] w, input logic s, input logic lr);
    eq.w_complete  = w;
    eq.r_submit    = s;
    eq.live_rising = lr;
    @(posedge clk);
    #1;
  endtask

  int order [6] = '{0, 1, 3, 0, 1, 3};
  logic [NCH-1:0] rw;
  logic rs, rl;
  int seg;

  initial begin
    eq.w_complete  = '0;
    eq.r_submit    = 1'b0;
    eq.live_rising = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst r_request", int'(eq.r_request), 0);
    chk("rst nqueue", int'(eq.nqueue), 0);
    chk("rst flags", int'({eq.overflow, eq.proto_err}), 0);
    rst_n = 1'b1;

    // single event on ch2
    cyc(4'b0100, 0, 0);
    chk("t31 ch2", dcnt(2), 1);
    chk("t31 req0", int'(eq.r_request), 0);
    cyc('0, 0, 0);
    chk("t31 req1", int'(eq.r_request), 1);
    chk("t31 rch", int'(eq.r_ch), 2);
    cyc('0, 1, 0);
    chk("t31 ch2 drained", dcnt(2), 0);
    chk("t31 arb", int'(eq.r_request), 0);
    cyc('0, 0, 0);
    chk("t31 idle", int'(eq.r_request), 0);

    // round robin over 0,1,3 with two events each
    cyc(4'b1011, 0, 1);
    cyc(4'b1011, 0, 0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t32 req g%0d", k), int'(eq.r_request), 1);
      chk($sformatf("t32 rch g%0d", k), int'(eq.r_ch), order[k]);
      cyc('0, 1, 0);
      chk($sformatf("t32 arb g%0d", k), int'(eq.r_request), 0);
      cyc('0, 0, 0);
    end
    chk("t32 idle", int'(eq.r_request), 0);
    chk("t32 empty", int'(eq.nqueue), 0);

    // fill ch1, coincident read/write at full, then overflow
    repeat (DEPTH) cyc(4'b0010, 0, 0);
    chk("t33 ch1 full cnt", dcnt(1), 32);
    chk("t33 full1", int'(eq.full[1]), 1);
    chk("t33 rch1", int'(eq.r_ch), 1);
    cyc(4'b0010, 1, 0);
    chk("t33 coincide cnt", dcnt(1), 32);
    chk("t33 coincide ovf", int'(eq.overflow[1]), 0);
    cyc(4'b0010, 0, 0);
    chk("t33 ovf cnt", dcnt(1), 32);
    chk("t33 ovf", int'(eq.overflow[1]), 1);

    // coincident read/write at 5, then a read with no request outstanding
    cyc(4'b0001, 0, 1);
    repeat (4) cyc(4'b0001, 0, 0);
    chk("t34 ch0", dcnt(0), 5);
    chk("t34 rch0", int'(eq.r_ch), 0);
    cyc(4'b0001, 1, 0);
    chk("t34 coincide", dcnt(0), 5);
    chk("t34 perr0", int'(eq.proto_err), 0);
    cyc('0, 1, 0);
    chk("t34 ignored", dcnt(0), 5);
    chk("t34 perr1", int'(eq.proto_err), 1);

    // live_rising mid-REQ with a write on ch3
    cyc(4'b1000, 1, 1);
    chk("t35 nqueue", int'(eq.nqueue), 1 << (3*CW));
    chk("t35 flags", int'({eq.overflow, eq.proto_err}), 0);
    chk("t35 req0", int'(eq.r_request), 0);
    cyc('0, 0, 0);
    chk("t35 req1", int'(eq.r_request), 1);
    chk("t35 rch3", int'(eq.r_ch), 3);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("t36 req", int'(eq.r_request), 0);
    chk("t36 rch", int'(eq.r_ch), 0);
    chk("t36 nqueue", int'(eq.nqueue), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 3000; k++) begin
      seg = (k / 250) % 3;
      rw  = (seg == 1) ? NCH'($urandom) : NCH'($urandom & $urandom);
      if (eq.r_request)
        rs = (seg == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      else
        rs = ($urandom_range(0, 49) == 0);
      rl = ($urandom_range(0, 299) == 0);
      cyc(rw, rs, rl);
    end
    cyc('0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/event_queue_arbiter.md
EVENT_QUEUE_ARBITER -- requirements
Module: event_queue_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4: number of event-queue channels (1..16).
REQ-002 SHALL have parameter DEPTH, default 32: per-channel queue capacity in events (2..255).
REQ-003 SHALL derive local constants CW = clog2(DEPTH+1) and CHW = max(1, clog2(NCH)).
REQ-004 SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port live_rising, input, 1: synchronous run-start clear.
REQ-007 SHALL have port w_complete, input, NCH: bit i pulses once per event written to channel i.
REQ-008 SHALL have port r_submit, input, 1: read control accepts the presented request this cycle.
REQ-009 SHALL have port r_request, output, 1: a read request is presented.
REQ-010 SHALL have port r_ch, output, CHW: channel index of the presented request.
REQ-011 SHALL have port nqueue, output, NCH*CW: per-channel occupancy; channel i at bits [i*CW +: CW].
REQ-012 SHALL have port full, output, NCH: bit i high when channel i occupancy equals DEPTH.
REQ-013 SHALL have port overflow, output, NCH: sticky; bit i set by a write to full channel i.
REQ-014 SHALL have port proto_err, output, 1: sticky; set by r_submit while r_request is low.

Function
REQ-015 SHALL keep one CW-bit occupancy counter per channel, all outputs registered.
REQ-016 SHALL increment counter i on w_complete[i] when not full; when full, counter holds and overflow[i] sets.
REQ-017 SHALL decrement counter r_ch on r_submit while r_request=1; counter never underflows.
REQ-018 SHALL leave counter i unchanged when w_complete[i] and a valid r_submit on channel i coincide, including when the counter is full (no overflow set).
REQ-019 SHALL accept simultaneous w_complete pulses on any number of channels in one cycle without loss.
REQ-020 SHALL implement FSM states IDLE, REQ, ARB.
REQ-021 IDLE: r_request=0; if any counter >0 (registered value), go to REQ next edge with r_ch = winner, r_request=1.
REQ-022 REQ: r_request=1, r_ch held stable; on r_submit go to ARB; otherwise stay.
REQ-023 ARB: r_request=0 for exactly one cycle; round-robin pointer = last served channel +1 (mod NCH); go to REQ if any counter >0 after the decrement, else IDLE.
REQ-024 SHALL arbitrate round-robin: winner is first non-empty channel at or after the pointer, wrapping NCH-1 to 0.
REQ-025 r_request latency: asserted two edges after the w_complete edge that makes the only non-empty channel non-empty (counter edge, then IDLE->REQ edge).
REQ-026 r_submit while r_request=0 SHALL be ignored for counters and SHALL set proto_err.
REQ-027 live_rising SHALL clear all counters, overflow, proto_err, pointer to 0, FSM to IDLE, r_request to 0; w_complete[i] in the same cycle leaves counter i = 1; r_submit in the same cycle is ignored.
REQ-028 full[i] SHALL be combinationally equal to (counter i == DEPTH).

Reset
REQ-029 rst_n low SHALL immediately force counters=0, r_request=0, r_ch=0, overflow=0, proto_err=0, pointer=0, FSM=IDLE.
REQ-030 SHALL leave reset state on the first clk edge after rst_n deasserts.

Verification
REQ-031 NCH=4: one w_complete[2] pulse -> nqueue ch2=1 next edge, r_request=1 with r_ch=2 one edge later; r_submit -> ch2=0, ARB, then IDLE.
REQ-032 Channels 0,1,3 each hold 2 events, pointer 0 -> grant order 0,1,3,0,1,3, one ARB cycle between grants, then IDLE.
REQ-033 DEPTH=32, ch1=32, w_complete[1] -> ch1 stays 32, overflow[1]=1; same cycle as valid r_submit on ch1 -> stays 32, overflow unchanged.
REQ-034 ch0=5, w_complete[0] and r_submit on r_ch=0 same cycle -> ch0 stays 5; r_submit with r_request=0 -> no count change, proto_err=1.
REQ-035 Mid-REQ with counters nonzero, live_rising with w_complete[3] -> all counters 0 except ch3=1, flags 0, r_request=0, re-request ch3 two edges later.
REQ-036 rst_n asserted mid-REQ between clock edges -> outputs zero without clock edge.
